// File: rtl/smg_encode_module.sv
// rtl/smg_encode_module.sv - 20-bit binary to six seven-segment patterns via sequential double-dabble
module smg_encode_module #(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [19:0] value_i,
  input  logic [5:0]  dp_i,
  input  logic        blank_en_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        ovf_o,
  output logic [7:0]  smg_1_o,
  output logic [7:0]  smg_2_o,
  output logic [7:0]  smg_3_o,
  output logic [7:0]  smg_4_o,
  output logic [7:0]  smg_5_o,
  output logic [7:0]  smg_6_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_ENC  = 2'd2
  } state_t;

  localparam logic [7:0]  BLANK_PAT = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [19:0] MAX_DEC   = 20'd999999;

  state_t          state_q, state_d;
  logic [19:0]     val_q, val_d;
  logic [19:0]     bin_q, bin_d;
  logic [23:0]     bcd_q, bcd_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [5:0]      dp_q, dp_d;
  logic            blank_q, blank_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            ovf_q, ovf_d;
  logic [5:0][7:0] seg_q, seg_d;

  logic [23:0]     bcd_adj;
  logic [5:0][7:0] enc_pat;
  logic            is_ovf;

  function automatic logic [7:0] digit_code(input logic [3:0] d);
    case (d)
      4'd0:    digit_code = 8'h3F;
      4'd1:    digit_code = 8'h06;
      4'd2:    digit_code = 8'h5B;
      4'd3:    digit_code = 8'h4F;
      4'd4:    digit_code = 8'h66;
      4'd5:    digit_code = 8'h6D;
      4'd6:    digit_code = 8'h7D;
      4'd7:    digit_code = 8'h07;
      4'd8:    digit_code = 8'h7F;
      4'd9:    digit_code = 8'h6F;
      default: digit_code = 8'h40;
    endcase
  endfunction

  // Add-3 correction applied to every nibble before the shift.
  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < 6; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end else begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4];
      end
    end
  end

  // Walk from the most significant digit so lead_zero tracks "this and all higher digits are 0".
  always_comb begin
    logic       lead_zero;
    logic [3:0] nib;
    logic [7:0] pat;
    is_ovf    = (val_q > MAX_DEC);
    lead_zero = 1'b1;
    enc_pat   = '0;
    nib       = '0;
    pat       = '0;
    for (int i = 5; i >= 0; i--) begin
      nib       = bcd_q[4*i +: 4];
      lead_zero = lead_zero & (nib == 4'd0);
      if (is_ovf) begin
        pat = 8'h40;
      end else if (blank_q && lead_zero && (i != 0)) begin
        pat = 8'h00;
      end else begin
        pat = digit_code(nib);
      end
      pat        = pat | {dp_q[i], 7'b0};
      enc_pat[i] = SEG_ACTIVE_LOW ? ~pat : pat;
    end
  end

  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    dp_d    = dp_q;
    blank_d = blank_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    seg_d   = seg_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          val_d   = value_i;
          bin_d   = value_i;
          dp_d    = dp_i;
          blank_d = blank_en_i;
          bcd_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        bcd_d = {bcd_adj[22:0], bin_q[19]};
        bin_d = {bin_q[18:0], 1'b0};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd19) begin
          state_d = S_ENC;
        end
      end
      S_ENC: begin
        seg_d   = enc_pat;
        ovf_d   = is_ovf;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      val_q   <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      dp_q    <= '0;
      blank_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      seg_q   <= {6{BLANK_PAT}};
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      dp_q    <= dp_d;
      blank_q <= blank_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      seg_q   <= seg_d;
    end
  end

  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign ovf_o   = ovf_q;
  assign smg_1_o = seg_q[0];
  assign smg_2_o = seg_q[1];
  assign smg_3_o = seg_q[2];
  assign smg_4_o = seg_q[3];
  assign smg_5_o = seg_q[4];
  assign smg_6_o = seg_q[5];

endmodule

// File: tb/tb_smg_encode_module.sv
// tb/tb_smg_encode_module.sv - scoreboard bench for smg_encode_module, both segment polarities
module tb_smg_encode_module;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [19:0] value_i;
  logic [5:0]  dp_i;
  logic        blank_en_i;

  logic        busy_hi, done_hi, ovf_hi;
  logic        busy_lo, done_lo, ovf_lo;
  logic [7:0]  hi1, hi2, hi3, hi4, hi5, hi6;
  logic [7:0]  lo1, lo2, lo3, lo4, lo5, lo6;
  logic [47:0] hi_all, lo_all;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic [47:0] hi;
    logic [47:0] lo;
    logic        ovf;
    int          due;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign hi_all = {hi6, hi5, hi4, hi3, hi2, hi1};
  assign lo_all = {lo6, lo5, lo4, lo3, lo2, lo1};

  smg_encode_module #(.SEG_ACTIVE_LOW(1'b0)) u_dut_hi (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .value_i(value_i),
    .dp_i(dp_i), .blank_en_i(blank_en_i),
    .busy_o(busy_hi), .done_o(done_hi), .ovf_o(ovf_hi),
    .smg_1_o(hi1), .smg_2_o(hi2), .smg_3_o(hi3),
    .smg_4_o(hi4), .smg_5_o(hi5), .smg_6_o(hi6)
  );

  smg_encode_module #(.SEG_ACTIVE_LOW(1'b1)) u_dut_lo (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .value_i(value_i),
    .dp_i(dp_i), .blank_en_i(blank_en_i),
    .busy_o(busy_lo), .done_o(done_lo), .ovf_o(ovf_lo),
    .smg_1_o(lo1), .smg_2_o(lo2), .smg_3_o(lo3),
    .smg_4_o(lo4), .smg_5_o(lo5), .smg_6_o(lo6)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_code(input int d);
    case (d)
      0: return 8'h3F;
      1: return 8'h06;
      2: return 8'h5B;
      3: return 8'h4F;
      4: return 8'h66;
      5: return 8'h6D;
      6: return 8'h7D;
      7: return 8'h07;
      8: return 8'h7F;
      default: return 8'h6F;
    endcase
  endfunction

  function automatic logic [47:0] ref_model(input int v, input logic [5:0] dp, input bit blank, input bit act_low);
    logic [47:0] r;
    logic [7:0]  pat;
    bit          lz;
    int          p;
    int          d;
    r  = '0;
    lz = 1'b1;
    p  = 100000;
    for (int i = 5; i >= 0; i--) begin
      d  = (v / p) % 10;
      lz = lz && (d == 0);
      if (v > 999999)            pat = 8'h40;
      else if (blank && lz && i > 0) pat = 8'h00;
      else                       pat = ref_code(d);
      if (dp[i]) pat = pat | 8'h80;
      if (act_low) pat = ~pat;
      r[8*i +: 8] = pat;
      p = p / 10;
    end
    return r;
  endfunction

  // Called at a negedge; drives start for one cycle and optionally expects a result.
  task automatic start_conv(input logic [19:0] v, input logic [5:0] dp, input bit blank, input bit expect_done);
    exp_t e;
    start_i    = 1'b1;
    value_i    = v;
    dp_i       = dp;
    blank_en_i = blank;
    if (expect_done) begin
      e.hi  = ref_model(int'(v), dp, blank, 1'b0);
      e.lo  = ref_model(int'(v), dp, blank, 1'b1);
      e.ovf = (v > 20'd999999);
      e.due = cyc + 22;
      sb_q.push_back(e);
    end
    @(negedge clk);
    start_i = 1'b0;
    check_eq("busy_after_start", {busy_lo, busy_hi}, 2'b11);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && sb_q.size() != 0; i++) @(negedge clk);
    check_eq("scoreboard_drained", sb_q.size(), 0);
    sb_q.delete();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_i && (done_hi || done_lo)) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_done", {done_lo, done_hi}, 2'b00);
      end else begin
        e = sb_q.pop_front();
        check_eq("seg_active_high", hi_all, e.hi);
        check_eq("seg_active_low", lo_all, e.lo);
        check_eq("ovf", {ovf_lo, ovf_hi}, {e.ovf, e.ovf});
        check_eq("done_both", {done_lo, done_hi}, 2'b11);
        check_eq("done_latency", cyc, e.due);
        check_eq("busy_cleared", {busy_lo, busy_hi}, 2'b00);
      end
    end
  end

  initial begin
    rst_i      = 1'b1;
    start_i    = 1'b0;
    value_i    = '0;
    dp_i       = '0;
    blank_en_i = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_hi_seg", hi_all, 48'h0);
    check_eq("reset_lo_seg", lo_all, 48'hFFFF_FFFF_FFFF);
    check_eq("reset_flags", {busy_hi, done_hi, ovf_hi, busy_lo, done_lo, ovf_lo}, 6'b0);
    rst_i = 1'b0;
    @(negedge clk);

    start_conv(20'd123456, 6'b0, 1'b0, 1'b1);
    wait_idle();
    check_eq("tp_123456", hi_all, 48'h065B_4F66_6D7D);

    start_conv(20'd42, 6'b000010, 1'b1, 1'b1);
    wait_idle();
    check_eq("tp_42_blank_dp", hi_all, 48'h0000_0000_E65B);

    start_conv(20'd0, 6'b0, 1'b1, 1'b1);
    wait_idle();
    check_eq("tp_zero_hi", hi_all, 48'h0000_0000_003F);
    check_eq("tp_zero_lo", lo_all, 48'hFFFF_FFFF_FFC0);

    start_conv(20'hF4240, 6'b0, 1'b1, 1'b1);
    wait_idle();
    check_eq("tp_ovf_dash", hi_all, 48'h4040_4040_4040);
    check_eq("tp_ovf_flag", ovf_hi, 1'b1);

    start_conv(20'd999999, 6'b0, 1'b0, 1'b1);
    wait_idle();
    check_eq("tp_999999", hi_all, 48'h6F6F_6F6F_6F6F);
    check_eq("tp_999999_ovf", ovf_hi, 1'b0);

    // Start ignored mid-conversion, then a start accepted in the done cycle.
    start_conv(20'd123456, 6'b0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    start_conv(20'd654321, 6'b111111, 1'b1, 1'b0);
    for (int i = 0; i < 40 && !done_hi; i++) @(negedge clk);
    check_eq("done_seen", done_hi, 1'b1);
    start_conv(20'd246810, 6'b100001, 1'b0, 1'b1);
    wait_idle();

    // Reset mid-conversion aborts without a done pulse.
    start_conv(20'd777777, 6'b0, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    check_eq("abort_busy", {busy_lo, busy_hi}, 2'b00);
    check_eq("abort_hi_seg", hi_all, 48'h0);
    check_eq("abort_lo_seg", lo_all, 48'hFFFF_FFFF_FFFF);
    rst_i = 1'b0;
    repeat (25) @(negedge clk);
    check_eq("abort_no_done", {done_lo, done_hi}, 2'b00);
    start_conv(20'd5, 6'b0, 1'b0, 1'b1);
    wait_idle();
    check_eq("restart_units", hi1, 8'h6D);

    for (int k = 0; k < 8; k++) begin
      start_conv(20'($urandom_range(0, 20'hFFFFF)), 6'($urandom), 1'($urandom), 1'b1);
      wait_idle();
    end
    start_conv(20'hFFFFF, 6'b010101, 1'b1, 1'b1);
    wait_idle();
    start_conv(20'd100000, 6'b0, 1'b1, 1'b1);
    wait_idle();

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
